nor_gate_reg: RTL and testbench

- Registered, parameterizable NOR unit with a valid/ready handshake.
- Computes the bitwise NOR of two WIDTH-bit operands, or a reduction NOR, and presents the result one cycle later.
- Serves as the clocked logic-gate primitive in the team's logic_gate library.
- With WIDTH=1 and mode 0 it implements the classic 2-input NOR truth table.

---
 rtl/logic_gate_pkg.sv | 14 +
 rtl/nor_gate_comb.sv | 34 +++
 rtl/nor_gate_reg.sv | 57 +++++
 tb/tb_nor_gate_reg.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_gate_pkg.sv
// Shared definitions for the logic_gate library: the operation-select encoding
// and the widest operand any gate in the library supports.
package logic_gate_pkg;

  localparam int MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    NOR_BIT    = 2'd0,
    NOR_RED_A  = 2'd1,
    NOR_RED_AB = 2'd2,
    NOR_RSVD   = 2'd3
  } nor_mode_e;

endpackage

// File: rtl/nor_gate_comb.sv
// Combinational NOR datapath: bitwise or reduction NOR selected by mode,
// with err flagging the reserved encoding.
module nor_gate_comb
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  always_comb begin
    result = '0;
    err    = 1'b0;
    case (mode)
      NOR_BIT:    result    = ~(a | b);
      NOR_RED_A:  result[0] = ~(|a);
      NOR_RED_AB: result[0] = ~((|a) | (|b));
      NOR_RSVD: begin
        // Reserved encoding still yields a usable bitwise NOR, but is flagged.
        result = ~(a | b);
        err    = 1'b1;
      end
      default: begin
        result = '0;
        err    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/nor_gate_reg.sv
// Registered NOR unit: one-deep output register behind a valid/ready
// handshake, giving single-cycle latency and full throughput.
module nor_gate_reg
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_any,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] result;
  logic             err;
  logic             capture;

  nor_gate_comb #(
    .WIDTH(WIDTH)
  ) u_comb (
    .a      (in_a),
    .b      (in_b),
    .mode   (mode),
    .result (result),
    .err    (err)
  );

  // Held low during reset so nothing is offered to a unit that cannot capture.
  assign in_ready = ~rst & (~out_valid | out_ready);
  assign capture  = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      out_any   <= 1'b0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
    end else if (capture) begin
      out       <= result;
      out_any   <= |result;
      out_err   <= err;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      // Drain only clears the flag; the data registers keep the last result.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nor_gate_reg.sv
// Scoreboard bench for nor_gate_reg at WIDTH 1, 4 and 8 with directed vectors.
module tb_nor_gate_reg;

  typedef struct {
    logic [63:0] o;
    logic        any;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  logic       a1, b1, iv1, ir1, o1, oa1, oe1, ov1, ordy1;
  logic [1:0] m1;
  logic [3:0] a4, b4, o4;
  logic       iv4, ir4, oa4, oe4, ov4, ordy4;
  logic [1:0] m4;
  logic [7:0] a8, b8, o8;
  logic       iv8, ir8, oa8, oe8, ov8, ordy8;
  logic [1:0] m8;

  exp_t q1[$];
  exp_t q4[$];
  exp_t q8[$];
  exp_t me;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nor_gate_reg #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_a(a1), .in_b(b1), .mode(m1), .in_valid(iv1),
    .in_ready(ir1), .out(o1), .out_any(oa1), .out_err(oe1), .out_valid(ov1),
    .out_ready(ordy1)
  );

  nor_gate_reg #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .in_a(a4), .in_b(b4), .mode(m4), .in_valid(iv4),
    .in_ready(ir4), .out(o4), .out_any(oa4), .out_err(oe4), .out_valid(ov4),
    .out_ready(ordy4)
  );

  nor_gate_reg #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_a(a8), .in_b(b8), .mode(m8), .in_valid(iv8),
    .in_ready(ir8), .out(o8), .out_any(oa8), .out_err(oe8), .out_valid(ov8),
    .out_ready(ordy8)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: actual event missing required event seen", name);
  endtask

  function automatic logic rdy(input int w);
    case (w)
      1:       return ir1;
      4:       return ir4;
      default: return ir8;
    endcase
  endfunction

  function automatic logic vld(input int w);
    case (w)
      1:       return ov1;
      4:       return ov4;
      default: return ov8;
    endcase
  endfunction

  task automatic push(input int w, input exp_t e);
    case (w)
      1:       q1.push_back(e);
      4:       q4.push_back(e);
      default: q8.push_back(e);
    endcase
  endtask

  // Drive one operand, wait (bounded) for acceptance, queue the expected
  // result, and confirm out_valid one cycle after the capture edge.
  task automatic send(input int w, input logic [63:0] a, input logic [63:0] b,
                      input logic [1:0] m, input logic [63:0] eo, input logic ee);
    exp_t e;
    bit   ok;
    e.o   = eo;
    e.any = |eo;
    e.err = ee;
    ok    = 1'b0;
    case (w)
      1:       begin a1 = a[0];   b1 = b[0];   m1 = m; iv1 = 1'b1; end
      4:       begin a4 = a[3:0]; b4 = b[3:0]; m4 = m; iv4 = 1'b1; end
      default: begin a8 = a[7:0]; b8 = b[7:0]; m8 = m; iv8 = 1'b1; end
    endcase
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (rdy(w)) begin
        push(w, e);
        ok = 1'b1;
      end
    end
    if (!ok) begin
      fail_now("send_timeout");
    end else begin
      @(posedge clk);
      #1;
      chk("latency_valid", {63'b0, vld(w)}, 64'd1);
    end
  endtask

  // Monitor: every transfer (valid & ready at the coming edge) pops one result.
  always @(negedge clk) begin
    if (!rst) begin
      if (ov1 && ordy1) begin
        if (q1.size() == 0) fail_now("w1_unexpected_result");
        else begin
          me = q1.pop_front();
          chk("w1_out", {63'b0, o1}, me.o);
          chk("w1_any", {63'b0, oa1}, {63'b0, me.any});
          chk("w1_err", {63'b0, oe1}, {63'b0, me.err});
        end
      end
      if (ov4 && ordy4) begin
        if (q4.size() == 0) fail_now("w4_unexpected_result");
        else begin
          me = q4.pop_front();
          chk("w4_out", {60'b0, o4}, me.o);
          chk("w4_any", {63'b0, oa4}, {63'b0, me.any});
          chk("w4_err", {63'b0, oe4}, {63'b0, me.err});
        end
      end
      if (ov8 && ordy8) begin
        if (q8.size() == 0) fail_now("w8_unexpected_result");
        else begin
          me = q8.pop_front();
          chk("w8_out", {56'b0, o8}, me.o);
          chk("w8_any", {63'b0, oa8}, {63'b0, me.any});
          chk("w8_err", {63'b0, oe8}, {63'b0, me.err});
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    a1 = 1'b0; b1 = 1'b0; m1 = 2'd0; iv1 = 1'b0; ordy1 = 1'b1;
    a4 = '0;   b4 = '0;   m4 = 2'd0; iv4 = 1'b0; ordy4 = 1'b1;
    a8 = '0;   b8 = '0;   m8 = 2'd0; iv8 = 1'b0; ordy8 = 1'b1;

    #2;
    chk("reset_out",      {56'b0, o8}, 64'd0);
    chk("reset_valid",    {63'b0, ov8}, 64'd0);
    chk("reset_in_ready", {63'b0, ir8}, 64'd0);
    chk("reset_any_err",  {62'b0, oa8, oe8}, 64'd0);

    @(posedge clk);
    #1;
    rst = 1'b0;

    // WIDTH=1 truth table, back-to-back
    send(1, 64'd0, 64'd0, 2'd0, 64'd1, 1'b0);
    send(1, 64'd1, 64'd0, 2'd0, 64'd0, 1'b0);
    send(1, 64'd0, 64'd1, 2'd0, 64'd0, 1'b0);
    send(1, 64'd1, 64'd1, 2'd0, 64'd0, 1'b0);
    iv1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Backpressure on WIDTH=8
    ordy8 = 1'b0;
    send(8, 64'hF0, 64'h0C, 2'd0, 64'h03, 1'b0);
    a8 = 8'h55; b8 = 8'h22; m8 = 2'd0; iv8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("stall_in_ready", {63'b0, ir8}, 64'd0);
      chk("stall_out",      {56'b0, o8}, 64'h03);
      chk("stall_valid",    {63'b0, ov8}, 64'd1);
    end
    ordy8 = 1'b1;
    me.o = 64'h88; me.any = 1'b1; me.err = 1'b0;
    push(8, me);
    @(posedge clk);
    #1;
    chk("replace_out",   {56'b0, o8}, 64'h88);
    chk("replace_valid", {63'b0, ov8}, 64'd1);
    iv8 = 1'b0;

    // WIDTH=8 bitwise and reduction modes
    send(8, 64'hFF, 64'h00, 2'd0, 64'h00, 1'b0);
    send(8, 64'h00, 64'h3C, 2'd1, 64'h01, 1'b0);
    send(8, 64'h80, 64'h00, 2'd1, 64'h00, 1'b0);
    send(8, 64'h00, 64'h10, 2'd2, 64'h00, 1'b0);
    send(8, 64'h00, 64'h00, 2'd2, 64'h01, 1'b0);
    iv8 = 1'b0;
    a8 = 'x; b8 = 'x;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("idle_hold_out",   {56'b0, o8}, 64'h01);
      chk("idle_hold_valid", {63'b0, ov8}, 64'd0);
    end

    // Reserved mode on WIDTH=4
    send(4, 64'hA, 64'h0, 2'd3, 64'h5, 1'b1);
    send(4, 64'h3, 64'h4, 2'd0, 64'h8, 1'b0);
    iv4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset while a result is stalled
    ordy8 = 1'b0;
    send(8, 64'hAA, 64'h00, 2'd0, 64'h55, 1'b0);
    iv8 = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out",      {56'b0, o8}, 64'd0);
    chk("async_rst_valid",    {63'b0, ov8}, 64'd0);
    chk("async_rst_any_err",  {62'b0, oa8, oe8}, 64'd0);
    chk("async_rst_in_ready", {63'b0, ir8}, 64'd0);
    q8.delete();
    ordy8 = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("post_rst_no_replay", {63'b0, ov8}, 64'd0);
    send(8, 64'h0F, 64'hF0, 2'd0, 64'h00, 1'b0);
    iv8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    chk("w1_queue_empty", 64'(q1.size()), 64'd0);
    chk("w4_queue_empty", 64'(q4.size()), 64'd0);
    chk("w8_queue_empty", 64'(q8.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
